// File: rtl/led_mmio_port.sv
// ============================================================================
// led_mmio_port
//
// Memory-mapped LED control port. It snoops the core write bus that feeds
// memory. It captures writes aimed at one word address into a control
// register, and drives eight LEDs through a PWM dimmer and an optional blinker.
//
// Control register layout:
//   [7:0]   pattern      LED on/off mask
//   [15:8]  duty         PWM duty (low pPwmBits bits are used)
//   [16]    blink enable (only with LED_MMIO_BLINK_EN)
//   [28:24] blink select (only with LED_MMIO_BLINK_EN)
//   All other bits read as 0.
//
// Optional feature macro: LED_MMIO_BLINK_EN
//   When defined, this adds a 32-bit free-running blink counter.
//   The LEDs are gated by counter bit [blink select] while blink enable is set.
//   When undefined, the blink bits are not writable and blinking is off.
//
// Parameters:
//   pLedAddr  word address of the control register (bits [1:0] ignored)
//   pPwmBits  PWM counter / duty width, 2..8
//
// Ports:
//   iwClk        clock, rising edge
//   iwRst        synchronous active-high reset
//   iwWriteAddr  core write address (byte address)
//   iwWriteData  core write data
//   iwWstrb      byte write strobes, nonzero = write this cycle
//   owLed        registered LED drive, 1 = lit
//   owRegData    current control register value
//   owWriteHit   one-cycle pulse following each accepted register write
// ============================================================================
module led_mmio_port #(
    parameter logic [31:0] pLedAddr = 32'h0000_0FFC,
    parameter int          pPwmBits = 8
) (
    input  logic        iwClk,
    input  logic        iwRst,
    input  logic [31:0] iwWriteAddr,
    input  logic [31:0] iwWriteData,
    input  logic [3:0]  iwWstrb,
    output logic [7:0]  owLed,
    output logic [31:0] owRegData,
    output logic        owWriteHit
);

    localparam logic [31:0] RESET_VAL = 32'h0000_FF00;

    // Only these bits hold state; the rest are forced to zero on every write.
`ifdef LED_MMIO_BLINK_EN
    localparam logic [31:0] WR_MASK = 32'h1F01_FFFF;
`else
    localparam logic [31:0] WR_MASK = 32'h0000_FFFF;
`endif

    localparam logic [pPwmBits-1:0] PWM_ONE = {{(pPwmBits-1){1'b0}}, 1'b1};

    logic [31:0]         reg_q;
    logic [31:0]         reg_d;
    logic                hit_q;
    logic [7:0]          led_q;
    logic [7:0]          led_d;
    logic [pPwmBits-1:0] pwm_cnt_q;
    logic                write_hit;
    logic [pPwmBits-1:0] duty;
    logic                pwm_on;
    logic                blink_on;

    // Address match ignores the byte offset inside the word.
    assign write_hit = (iwWstrb != 4'b0000) && (iwWriteAddr[31:2] == pLedAddr[31:2]);

    // Byte-lane merge: strobed lanes take masked write data, others hold.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign reg_d[8*gi +: 8] = (write_hit && iwWstrb[gi])
                                    ? (iwWriteData[8*gi +: 8] & WR_MASK[8*gi +: 8])
                                    : reg_q[8*gi +: 8];
        end
    endgenerate

    assign duty = reg_q[8 +: pPwmBits];

    // An all-ones duty would leave one dark slot per period with a plain
    // compare, so it is treated as fully on. Duty 0 never satisfies cnt < 0.
    assign pwm_on = (&duty) || (pwm_cnt_q < duty);

`ifdef LED_MMIO_BLINK_EN
    logic [31:0] blink_cnt_q;

    assign blink_on = !reg_q[16] || blink_cnt_q[reg_q[28:24]];

    always_ff @(posedge iwClk) begin
        if (iwRst) begin
            blink_cnt_q <= 32'd0;
        end else begin
            blink_cnt_q <= blink_cnt_q + 32'd1;
        end
    end
`else
    assign blink_on = 1'b1;
`endif

    assign led_d = reg_q[7:0] & {8{pwm_on && blink_on}};

    always_ff @(posedge iwClk) begin
        if (iwRst) begin
            reg_q     <= RESET_VAL;
            hit_q     <= 1'b0;
            led_q     <= 8'h00;
            pwm_cnt_q <= '0;
        end else begin
            reg_q     <= reg_d;
            hit_q     <= write_hit;
            led_q     <= led_d;
            pwm_cnt_q <= pwm_cnt_q + PWM_ONE;
        end
    end

    assign owLed      = led_q;
    assign owRegData  = reg_q;
    assign owWriteHit = hit_q;

endmodule

// File: tb/tb_led_mmio_port.sv
// ============================================================================
// tb_led_mmio_port
//
// Directed testbench for led_mmio_port with default parameters.
// Each scenario task drives the bus and compares DUT outputs against
// hand-computed values. Inputs change 1 time unit after the rising edge, and
// outputs are sampled at that same point.
// Honours LED_MMIO_BLINK_EN to pick the matching expectations.
// ============================================================================
module tb_led_mmio_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] waddr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  wstrb = 4'd0;
    logic [7:0]  led;
    logic [31:0] regdata;
    logic        hit;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    led_mmio_port dut (
        .iwClk       (clk),
        .iwRst       (rst),
        .iwWriteAddr (waddr),
        .iwWriteData (wdata),
        .iwWstrb     (wstrb),
        .owLed       (led),
        .owRegData   (regdata),
        .owWriteHit  (hit)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one write for a single edge, then drop the strobes.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        $display("write addr=%08h data=%08h strb=%04b", a, d, s);
        waddr = a;
        wdata = d;
        wstrb = s;
        tick();
        wstrb = 4'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        chk_cnt++;
        if (regdata !== 32'h0000_FF00) $display("FAIL reset_reg got=%08h exp=%08h", regdata, 32'h0000_FF00);
        else pass_cnt++;
        chk_cnt++;
        if (led !== 8'h00) $display("FAIL reset_led got=%02h exp=00", led);
        else pass_cnt++;
        chk_cnt++;
        if (hit !== 1'b0) $display("FAIL reset_hit got=%0b exp=0", hit);
        else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_pattern();
        int bad;
        do_write(32'h0000_0FFC, 32'h0000_FF5A, 4'b0001);
        chk_cnt++;
        if (hit !== 1'b1) $display("FAIL pattern_hit got=%0b exp=1", hit);
        else pass_cnt++;
        chk_cnt++;
        if (regdata !== 32'h0000_FF5A) $display("FAIL pattern_reg got=%08h exp=0000ff5a", regdata);
        else pass_cnt++;
        chk_cnt++;
        if (led !== 8'h00) $display("FAIL pattern_led_latency got=%02h exp=00", led);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (hit !== 1'b0) $display("FAIL pattern_single_pulse got=%0b exp=0", hit);
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (led !== 8'h5A) bad++;
            tick();
        end
        chk_cnt++;
        if (bad != 0) $display("FAIL pattern_led_steady bad_cycles=%0d exp=0", bad);
        else pass_cnt++;
    endtask

    task automatic test_duty();
        int on_cnt;
        int other;
        do_write(32'h0000_0FFC, 32'h0000_00FF, 4'b0001);
        do_write(32'h0000_0FFC, 32'h0000_4000, 4'b0010);
        chk_cnt++;
        if (regdata !== 32'h0000_40FF) $display("FAIL duty_reg got=%08h exp=000040ff", regdata);
        else pass_cnt++;
        tick();
        on_cnt = 0;
        other  = 0;
        for (int i = 0; i < 256; i++) begin
            if (led === 8'hFF) on_cnt++;
            else if (led !== 8'h00) other++;
            tick();
        end
        chk_cnt++;
        if (on_cnt != 64 || other != 0)
            $display("FAIL duty_pwm on_cycles=%0d other=%0d exp on=64 other=0", on_cnt, other);
        else pass_cnt++;
    endtask

    // Reset mid-period, then write duty 4: LEDs must be lit exactly while
    // the restarted counter is 1..3 in the observed window (0 was before).
    task automatic test_reset_restart();
        logic [7:0] exp_led [4] = '{8'hFF, 8'hFF, 8'hFF, 8'h00};
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        do_write(32'h0000_0FFC, 32'h0000_04FF, 4'b0011);
        chk_cnt++;
        if (led !== 8'h00) $display("FAIL restart_led0 got=%02h exp=00", led);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_cnt++;
            if (led !== exp_led[i]) $display("FAIL restart_led%0d got=%02h exp=%02h", i + 1, led, exp_led[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_addr_miss();
        do_write(32'h0000_0FF8, 32'hFFFF_FFFF, 4'b1111);
        chk_cnt++;
        if (hit !== 1'b0 || regdata !== 32'h0000_04FF)
            $display("FAIL miss_ff8 hit=%0b reg=%08h exp hit=0 reg=000004ff", hit, regdata);
        else pass_cnt++;
        do_write(32'h0000_1FFC, 32'hFFFF_FFFF, 4'b0001);
        chk_cnt++;
        if (hit !== 1'b0 || regdata !== 32'h0000_04FF)
            $display("FAIL miss_1ffc hit=%0b reg=%08h exp hit=0 reg=000004ff", hit, regdata);
        else pass_cnt++;
    endtask

    task automatic test_strobe_offset();
        do_write(32'h0000_0FFE, 32'h0000_00AA, 4'b0000);
        chk_cnt++;
        if (hit !== 1'b0 || regdata !== 32'h0000_04FF)
            $display("FAIL zero_strobe hit=%0b reg=%08h exp hit=0 reg=000004ff", hit, regdata);
        else pass_cnt++;
        do_write(32'h0000_0FFD, 32'h0000_00AA, 4'b0001);
        chk_cnt++;
        if (hit !== 1'b1 || regdata !== 32'h0000_04AA)
            $display("FAIL byte_offset hit=%0b reg=%08h exp hit=1 reg=000004aa", hit, regdata);
        else pass_cnt++;
    endtask

    task automatic test_reset_priority();
        rst = 1'b1;
        do_write(32'h0000_0FFC, 32'h0000_0012, 4'b0001);
        chk_cnt++;
        if (regdata !== 32'h0000_FF00 || led !== 8'h00 || hit !== 1'b0)
            $display("FAIL reset_prio reg=%08h led=%02h hit=%0b exp reg=0000ff00 led=00 hit=0", regdata, led, hit);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        chk_cnt++;
        if (hit !== 1'b0 || regdata !== 32'h0000_FF00)
            $display("FAIL reset_prio_after hit=%0b reg=%08h exp hit=0 reg=0000ff00", hit, regdata);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int pulses;
        $display("write addr=00000ffc data=000080c3 strb=0011 held 3 cycles");
        waddr  = 32'h0000_0FFC;
        wdata  = 32'h0000_80C3;
        wstrb  = 4'b0011;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (hit === 1'b1) pulses++;
        end
        wstrb = 4'd0;
        tick();
        if (hit === 1'b1) pulses++;
        chk_cnt++;
        if (pulses != 3) $display("FAIL held_pulses got=%0d exp=3", pulses);
        else pass_cnt++;
        chk_cnt++;
        if (regdata !== 32'h0000_80C3) $display("FAIL held_reg got=%08h exp=000080c3", regdata);
        else pass_cnt++;
    endtask

    task automatic test_upper_bits();
        logic [31:0] exp_reg;
`ifdef LED_MMIO_BLINK_EN
        exp_reg = 32'h1F01_80C3;
`else
        exp_reg = 32'h0000_80C3;
`endif
        do_write(32'h0000_0FFC, 32'hFFFF_FFFF, 4'b1100);
        chk_cnt++;
        if (hit !== 1'b1 || regdata !== exp_reg)
            $display("FAIL upper_bits hit=%0b reg=%08h exp hit=1 reg=%08h", hit, regdata, exp_reg);
        else pass_cnt++;
    endtask

    task automatic test_blink();
        logic [31:0] exp_reg;
        logic        s [48];
        int          bad;
`ifdef LED_MMIO_BLINK_EN
        exp_reg = 32'h0301_FF01;
`else
        exp_reg = 32'h0000_FF01;
`endif
        do_write(32'h0000_0FFC, 32'h0301_FF01, 4'b1111);
        chk_cnt++;
        if (regdata !== exp_reg) $display("FAIL blink_reg got=%08h exp=%08h", regdata, exp_reg);
        else pass_cnt++;
        tick();
        for (int i = 0; i < 48; i++) begin
            s[i] = led[0];
            tick();
        end
        bad = 0;
`ifdef LED_MMIO_BLINK_EN
        // Blink select 3: bit 3 of the counter flips every 8 cycles.
        for (int i = 0; i < 40; i++) if (s[i + 8] === s[i]) bad++;
`else
        for (int i = 0; i < 48; i++) if (s[i] !== 1'b1) bad++;
`endif
        chk_cnt++;
        if (bad != 0) $display("FAIL blink_led0 bad_samples=%0d exp=0", bad);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_duty();
        test_reset_restart();
        test_addr_miss();
        test_strobe_offset();
        test_reset_priority();
        test_back_to_back();
        test_upper_bits();
        test_blink();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/led_mmio_port.md
LED_MMIO_PORT -- requirements
Module: led_mmio_port

Interface
REQ-001 The block SHALL expose parameter pLedAddr, default 32'h0000_0FFC, giving the word address of the LED control register.
REQ-002 The block SHALL expose parameter pPwmBits, default 8, giving the PWM counter and duty width (legal range 2..8).
REQ-003 Port iwClk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port iwRst  input  1  reset, synchronous and active-high.
REQ-005 Port iwWriteAddr  input  32  core write address, byte-addressed.
REQ-006 Port iwWriteData  input  32  core write data.
REQ-007 Port iwWstrb  input  4  byte write strobes; any nonzero value is a write in that cycle.
REQ-008 Port owLed  output  8  registered LED drive, 1 = lit.
REQ-009 Port owRegData  output  32  current control register value.
REQ-010 Port owWriteHit  output  1  registered one-cycle pulse per accepted register write.

Function
REQ-011 The block SHALL sit downstream of the core write port, snooping the same address, data and strobe bus that feeds memory.
REQ-012 A write SHALL be accepted when iwWstrb != 0 and iwWriteAddr[31:2] == pLedAddr[31:2]; iwWriteAddr[1:0] SHALL be ignored.
REQ-013 Each accepted write SHALL update only the bytes whose strobes are set; unstrobed bytes hold.
REQ-014 Control register layout SHALL be: [7:0] pattern, [15:8] duty, bit 16 blink enable, [28:24] blink select, all other bits read as 0 and not writable.
REQ-015 An accepted write at edge N SHALL appear on owRegData after edge N and on owLed after edge N+1.
REQ-016 owWriteHit SHALL be 1 for exactly the cycle following each edge with an accepted write; a write held for k cycles yields k pulses, with identical register results.
REQ-017 A free-running pPwmBits-bit PWM counter SHALL increment every cycle and wrap from all-ones to 0.
REQ-018 Duty SHALL be duty[pPwmBits-1:0], aligned to bit 8 of the register.
REQ-019 PWM on-phase SHALL be counter < duty; duty all-ones SHALL force the on-phase continuously; duty 0 SHALL force LEDs off.
REQ-020 owLed[i] SHALL equal pattern[i] AND pwm_on AND blink_on, registered.
REQ-021 A duty change SHALL take effect at the next compare without resetting the PWM counter.
REQ-022 Non-matching addresses and zero strobes SHALL leave all state except the counters unchanged.

Reset
REQ-023 When iwRst is high at an edge, the register SHALL load 32'h0000_FF00, owLed 0, owWriteHit 0, and both counters 0.
REQ-024 Reset SHALL take priority over a simultaneous accepted write; that write is discarded and produces no pulse.
REQ-025 Reset asserted mid-PWM or mid-blink period SHALL restart both counters from 0 on the following cycle.

Configuration
REQ-026 With macro LED_MMIO_BLINK_EN defined, a 32-bit blink counter SHALL increment every cycle.
REQ-027 When blink is enabled, blink_on SHALL equal blink counter bit [blink select].
REQ-028 When blink enable is 0, blink_on SHALL be 1.
REQ-029 Without LED_MMIO_BLINK_EN, the blink counter SHALL be absent, blink_on SHALL be 1, and register bits 16 and [28:24] SHALL read 0 and ignore writes.

Verification
REQ-030 Reset, then write addr 0xFFC, data 0x0000FF5A, strobe 4'b0001 -> owWriteHit pulses once; owRegData 0x0000FF5A; owLed 0x5A steady from edge N+1.
REQ-031 With pattern 0xFF, write 0x00004000 with strobe 4'b0010 -> owRegData 0x000040FF; owLed 0xFF for 64 of every 256 cycles.
REQ-032 Write to addr 0xFF8 or 0x1FFC with any strobe -> no owWriteHit pulse; owRegData unchanged.
REQ-033 Write addr 0xFFE, data 0xAA, strobe 0 -> no effect; same write with strobe 4'b0001 and addr 0xFFD -> pattern 0xAA.
REQ-034 iwRst high in the same cycle as an accepted write of 0x12 -> owRegData 0x0000FF00, owLed 0, no pulse.
REQ-035 With LED_MMIO_BLINK_EN defined, write 0x0301FF01 -> owLed[0] toggles every 8 cycles; the same run without the macro -> owLed[0] constantly 1 and owRegData 0x0000FF01.
